// File: rtl/memfifo_pkg.sv
// Shared widths and buffer sizing for the memory-FIFO to EZ-USB read path.
package memfifo_pkg;
  localparam int FIFO_W    = 32;
  localparam int USB_W     = 16;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 32;

  // Buffer occupancy 0..BUF_DEPTH.
  typedef logic [1:0] occ_t;
endpackage

// File: rtl/unpack_buf.sv
// Two-entry ring buffer holding whole FIFO words until both halves are sent.
module unpack_buf
  import memfifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [FIFO_W-1:0] din,
  output logic [FIFO_W-1:0] dout,
  output occ_t              count
);
  logic [FIFO_W-1:0] mem_q [BUF_DEPTH];
  logic [FIFO_W-1:0] mem_d [BUF_DEPTH];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  occ_t              count_q, count_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = din;
      tail_d        = ~tail_q;
    end
    if (pop) head_d = ~head_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + occ_t'(1);
      2'b01:   count_d = count_q - occ_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: storage is reset as well so the head word, and thus usb_di, reads 0 after reset.
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/fifo_usb_unpacker.sv
// Prefetches 32-bit FIFO words and streams them to ezusb_io as 16-bit halves.
module fifo_usb_unpacker
  import memfifo_pkg::*;
#(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic              ifclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [FIFO_W-1:0] fifo_do,
  input  logic              fifo_empty,
  input  logic              fifo_rderr,
  output logic              fifo_rden,
  output logic [USB_W-1:0]  usb_di,
  output logic              usb_di_valid,
  input  logic              usb_di_ready,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              rderr_sticky
);
  logic              pend_q, pend_d;
  logic              half_q, half_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              rderr_q, rderr_d;
  occ_t              buf_count;
  logic [FIFO_W-1:0] head_data;
  logic              xfer;
  logic              pop;

  // Buffered plus in-flight words may never exceed the buffer depth.
  assign fifo_rden = enable && !fifo_empty && !reset &&
                     (({1'b0, buf_count} + {2'b00, pend_q}) < 3'(BUF_DEPTH));

  assign usb_di_valid = (buf_count != '0);
  assign usb_di       = (half_q ^ HI_FIRST) ? head_data[FIFO_W-1:USB_W]
                                            : head_data[USB_W-1:0];
  assign xfer         = usb_di_valid && usb_di_ready;
  assign pop          = xfer && half_q;

  always_comb begin
    pend_d     = fifo_rden;
    half_d     = half_q ^ xfer;
    word_cnt_d = word_cnt_q + CNT_W'(xfer);
    rderr_d    = rderr_q | fifo_rderr;
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      half_q     <= 1'b0;
      word_cnt_q <= '0;
      rderr_q    <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      half_q     <= half_d;
      word_cnt_q <= word_cnt_d;
      rderr_q    <= rderr_d;
    end
  end

  unpack_buf u_buf (
    .clk   (ifclk),
    .reset (reset),
    .push  (pend_q),
    .pop   (pop),
    .din   (fifo_do),
    .dout  (head_data),
    .count (buf_count)
  );

  assign word_cnt     = word_cnt_q;
  assign rderr_sticky = rderr_q;
endmodule

// File: doc/fifo_usb_unpacker.md
# fifo_usb_unpacker

Read-side stage between the 32-bit BRAM/SDRAM FIFO output port and the 16-bit FPGA→EZ-USB data path of `ezusb_io`. It issues FIFO reads through a prefetch buffer that covers the FIFO's one-cycle read latency, and splits each 32-bit word into two 16-bit USB words. With continuous `usb_di_ready` it sustains one 16-bit word per clock. It also keeps a transferred-word count and a sticky read-error flag for the debug LEDs.

## Interface
- `HI_FIRST`, default 0: 0 sends bits [15:0] of each FIFO word first, 1 sends bits [31:16] first.
- `ifclk` in 1: the only clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `enable` in 1: 1 allows new FIFO reads; 0 stops new reads while buffered data keeps draining.
- `fifo_do` in 32: FIFO read data; valid on the clock after the read strobe.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rderr` in 1: FIFO read-error flag.
- `fifo_rden` out 1: FIFO read strobe; combinational.
- `usb_di` out 16: data to `ezusb_io` DI.
- `usb_di_valid` out 1: to `ezusb_io` DI_valid.
- `usb_di_ready` in 1: from `ezusb_io` DI_ready.
- `word_cnt` out 32: count of 16-bit words transferred; wraps modulo 2^32.
- `rderr_sticky` out 1: latched `fifo_rderr`.

## Operation
- **State:**
  - two-entry 32-bit buffer: `head`/`tail` index, `count` (0..2);
  - `pend` (0/1): a read is in flight;
  - `half` (0/1): which half of the head entry is presented;
  - `word_cnt`, `rderr_sticky`.
- **Read issue:** `fifo_rden = enable && !fifo_empty && !reset && (count + pend < 2)`. `pend` follows `fifo_rden` one clock later.
- **Capture:** when `pend` = 1, `fifo_do` is written to the tail entry and `count` increments.
- **Output:**
  - `usb_di_valid = (count != 0)`.
  - `usb_di` = head entry half selected by `half XOR HI_FIRST`, where selector 0 is [15:0] and selector 1 is [31:16].
  - Both outputs are driven directly from registers; there is no combinational path from `usb_di_ready`.
- **Transfer:** occurs when `usb_di_valid && usb_di_ready`. Each transfer toggles `half` and increments `word_cnt`. A transfer with `half` = 1 pops the head: `count` decrements and `head` advances.
- **Simultaneous capture and pop:** `count` is unchanged and `tail`/`head` both advance.
- **Holding:** while `usb_di_ready` = 0, `usb_di` and `usb_di_valid` hold their values.
- **`enable` falling:** no new reads are issued; an in-flight read still captures; the buffer drains completely.
- **Error flag:** `rderr_sticky <= rderr_sticky | fifo_rderr`; it clears only on reset.
- **Invariant:** `count + pend <= 2` always. An overflow is impossible by construction; the bench asserts it.

## Timing
- **Reset values:** `fifo_rden`=0, `usb_di_valid`=0, `usb_di`=0, `word_cnt`=0, `rderr_sticky`=0, `count`=0, `pend`=0, `half`=0.
- **Latency:**
  - FIFO non-empty with buffer idle in cycle N: `fifo_rden`=1 in N.
  - Data captured at the end of N+1.
  - `usb_di_valid`=1 in N+2, first half presented.
- **Throughput:** with `usb_di_ready` held high and the FIFO never empty, `usb_di_valid` stays high every cycle after the first word. The two-entry buffer covers the read latency, so there are no bubbles.
- **Reset mid-operation:**
  - Buffered data and any in-flight read are discarded.
  - `fifo_rden` is low in the reset cycle.
  - A read issued in the cycle before reset is not captured; this is an accepted data loss, because the FIFO is reset together with this block.
- **`fifo_empty` rising** in the cycle after a read: no effect on the in-flight capture.

## Structure
- **Package `memfifo_pkg`:**
  - `FIFO_W = 32`, `USB_W = 16`;
  - `BUF_DEPTH = 2`;
  - `CNT_W = 32` for `word_cnt`.
- **Sub-module `unpack_buf`:** the two-entry buffer with `push`/`pop`/`count`, data in 32 bits and head data out 32 bits. The top level holds the read-issue logic, `half` select, counters and error flag.

## Test plan
- **Basic order:** reset, FIFO preloaded with 0x04030201, 0x08070605, `usb_di_ready`=1.
  - Required: `usb_di` sequence 0x0201, 0x0403, 0x0605, 0x0807 on four consecutive valid cycles.
  - First valid two cycles after the first `fifo_rden`; `word_cnt`=4.
- **`HI_FIRST`=1**, same data: sequence 0x0403, 0x0201, 0x0807, 0x0605.
- **Backpressure:** toggle `usb_di_ready` randomly over 1000 FIFO words of an incrementing pattern.
  - Required: no word lost or duplicated; `usb_di` stable while ready=0; `count + pend <= 2` always.
  - Final `word_cnt` = 2000.
- **Enable:** `enable` dropped with the FIFO full.
  - Required: at most one further read; valid deasserts after the buffered words drain.
  - Re-enabling resumes without gaps in the data sequence.
- **Reset:** reset asserted mid-stream with `count`=2.
  - Required: next cycle `usb_di_valid`=0 and `word_cnt`=0; the stale word is never output.
- **Read error:** pulse `fifo_rderr` for one cycle.
  - Required: `rderr_sticky`=1 until reset; the data path is unaffected.
